// File: rtl/mc_seq_pkg.sv
// Shared definitions for the 6502 microcode sequencer: NEXT field encodings,
// microcode word field positions, cycle-state names and the BRK opcode that
// is injected for interrupt and reset sequences.
package mc_seq_pkg;

  localparam int unsigned NEXT_LSB    = 0;
  localparam int unsigned NEXT_W      = 2;
  localparam int unsigned CLI_SEI_BIT = 2;

  localparam logic [7:0] OP_BRK = 8'h00;

  typedef enum logic [1:0] {
    NEXT_ADV     = 2'b00,
    NEXT_END     = 2'b01,
    NEXT_BRANCH  = 2'b10,
    NEXT_PAGEFIX = 2'b11
  } next_e;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } tstate_e;

endpackage

// File: rtl/mc_sequencer_int_latch.sv
// Interrupt latch for the sequencer.
//   clk, reset : core clock, synchronous active-high reset
//   ce         : CPU cycle enable; nothing (including nmi_prev) moves when low
//   nmi_n      : edge-triggered NMI request, active-low
//   irq_n      : level IRQ request, active-low
//   iflag      : processor I flag (masks IRQ)
//   fetch      : a T0 cycle with ce=1 is happening this cycle
//   int_take   : an interrupt sequence must be injected at this T0
//   nmi_pend   : a latched NMI edge is waiting to be taken
module int_latch (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic nmi_n,
  input  logic irq_n,
  input  logic iflag,
  input  logic fetch,
  output logic int_take,
  output logic nmi_pend
);

  logic nmi_prev;
  logic nmi_fall;

  always_comb begin
    nmi_fall = ce && nmi_prev && !nmi_n;
    int_take = nmi_pend || (!irq_n && !iflag);
  end

  // Any fetch with a pending NMI consumes it; a new edge in that same
  // cycle re-arms it.
  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_prev <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      if (ce) nmi_prev <= nmi_n;
      if (nmi_fall) nmi_pend <= 1'b1;
      else if (fetch) nmi_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Instruction sequencer for the NES 6502 core. Owns the opcode register and
// the T-state counter that address the microcode table, applies the table's
// NEXT field, and injects BRK for interrupt/reset sequences.
//   clk, reset   : core clock, synchronous active-high reset
//   ce           : CPU cycle enable
//   DI           : data bus, opcode during T0
//   Mout         : microcode word for {IR, State}; only NEXT is acted on
//   branch_taken : branch condition (NEXT=BRANCH)
//   page_cross   : low-byte carry (NEXT=PAGEFIX)
//   irq_n, nmi_n : interrupt requests, active-low
//   iflag        : processor I flag
//   IR, State    : opcode register and cycle state T0..T6
//   sync         : registered, high while State==T0
//   in_int       : current BRK is injected (interrupt/reset)
//   is_nmi       : injected sequence uses the NMI vector
module mc_sequencer
  import mc_seq_pkg::*;
#(
  parameter logic [2:0] RESET_STATE = 3'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [7:0]  DI,
  input  logic [37:0] Mout,
  input  logic        branch_taken,
  input  logic        page_cross,
  input  logic        irq_n,
  input  logic        nmi_n,
  input  logic        iflag,
  output logic [7:0]  IR,
  output logic [2:0]  State,
  output logic        sync,
  output logic        in_int,
  output logic        is_nmi
);

  tstate_e    state_q;
  tstate_e    state_nx;
  next_e      nxt;
  logic [2:0] state_inc;
  logic       advance;
  logic       fetch;
  logic       int_take;
  logic       nmi_pend;

  // CLI_SEI_DONE and the datapath fields belong to other blocks.
  logic unused_mout;
  assign unused_mout = ^{Mout[37:3], Mout[CLI_SEI_BIT]};

  assign State = state_q;

  int_latch u_int_latch (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .nmi_n    (nmi_n),
    .irq_n    (irq_n),
    .iflag    (iflag),
    .fetch    (fetch),
    .int_take (int_take),
    .nmi_pend (nmi_pend)
  );

  always_comb begin
    nxt       = next_e'(Mout[NEXT_LSB +: NEXT_W]);
    fetch     = ce && (state_q == T0);
    state_inc = state_q + 3'd1;
    advance   = 1'b0;
    case (nxt)
      NEXT_ADV:     advance = 1'b1;
      NEXT_END:     advance = 1'b0;
      NEXT_BRANCH:  advance = branch_taken;
      NEXT_PAGEFIX: advance = page_cross;
      default:      advance = 1'b0;
    endcase
    // An increment past T6 means broken microcode; end the instruction.
    if (state_q == T0) state_nx = T1;
    else if (advance && (state_inc != 3'd7)) state_nx = tstate_e'(state_inc);
    else state_nx = T0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= tstate_e'(RESET_STATE);
      IR      <= OP_BRK;
      sync    <= 1'b0;
      in_int  <= 1'b1;
      is_nmi  <= 1'b0;
    end else if (ce) begin
      state_q <= state_nx;
      sync    <= (state_nx == T0);
      if (state_q == T0) begin
        if (int_take) begin
          IR     <= OP_BRK;
          in_int <= 1'b1;
          is_nmi <= nmi_pend;
        end else begin
          IR     <= DI;
          in_int <= 1'b0;
          is_nmi <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: a cycle-level reference model derived from
// the instruction-sequencing rules is compared against every output on each
// falling edge, and directed literal checks pin the model at key points.
module tb_mc_sequencer;

  localparam logic [1:0] ADV = 2'b00, ENDI = 2'b01, BR = 2'b10, PF = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic [7:0]  DI = 8'h00;
  logic [37:0] Mout = '0;
  logic        branch_taken = 1'b0;
  logic        page_cross = 1'b0;
  logic        irq_n = 1'b1;
  logic        nmi_n = 1'b1;
  logic        iflag = 1'b1;
  logic [7:0]  IR;
  logic [2:0]  State;
  logic        sync;
  logic        in_int;
  logic        is_nmi;

  int total = 0;
  int bad = 0;

  mc_sequencer #(.RESET_STATE(3'd1)) dut (
    .clk(clk), .reset(reset), .ce(ce), .DI(DI), .Mout(Mout),
    .branch_taken(branch_taken), .page_cross(page_cross),
    .irq_n(irq_n), .nmi_n(nmi_n), .iflag(iflag),
    .IR(IR), .State(State), .sync(sync), .in_int(in_int), .is_nmi(is_nmi)
  );

  always #5 clk = ~clk;

  // Reference model.
  int  m_st, m_ir;
  bit  m_sync, m_int, m_nmi, m_pend, m_prev, m_valid = 0;

  always @(posedge clk) begin
    int  nst;
    bit  go, fall, used;
    if (reset) begin
      m_st = 1; m_ir = 0; m_int = 1; m_nmi = 0; m_sync = 0;
      m_pend = 0; m_prev = 1; m_valid = 1;
    end else if (ce) begin
      fall = m_prev && !nmi_n;
      used = 0;
      if (m_st == 0) begin
        if (m_pend || (!irq_n && !iflag)) begin
          m_ir = 0; m_int = 1; m_nmi = m_pend; used = m_pend;
        end else begin
          m_ir = DI; m_int = 0; m_nmi = 0;
        end
        nst = 1;
      end else begin
        case (Mout[1:0])
          ADV:     go = 1;
          ENDI:    go = 0;
          BR:      go = branch_taken;
          default: go = page_cross;
        endcase
        nst = go ? m_st + 1 : 0;
        if (nst == 7) nst = 0;
      end
      if (fall) m_pend = 1;
      else if (used) m_pend = 0;
      m_prev = nmi_n;
      m_st = nst;
      m_sync = (nst == 0);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      total++;
      if (State !== 3'(m_st) || IR !== 8'(m_ir) || sync !== m_sync ||
          in_int !== m_int || is_nmi !== m_nmi) begin
        bad++;
        $display("FAIL model t=%0t got st=%0d ir=%h sync=%b int=%b nmi=%b want st=%0d ir=%h sync=%b int=%b nmi=%b",
                 $time, State, IR, sync, in_int, is_nmi, m_st, m_ir, m_sync, m_int, m_nmi);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One clock; inputs change 1 time unit after the edge, outputs read there too.
  task automatic step(input bit c, input logic [1:0] nx, input logic [7:0] d,
                      input bit bt = 0, input bit pc = 0);
    ce = c;
    Mout = {$urandom(), $urandom()} & 38'h3F_FFFF_FFFC | 38'(nx);
    DI = d;
    branch_taken = bt;
    page_cross = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input int st, input int ir,
                         input int sy, input int ii, input int nm);
    chk({name, ".State"}, State, st);
    chk({name, ".IR"}, IR, ir);
    chk({name, ".sync"}, sync, sy);
    chk({name, ".in_int"}, in_int, ii);
    chk({name, ".is_nmi"}, is_nmi, nm);
  endtask

  initial begin
    // Reset state.
    reset = 1; step(0, ENDI, 8'h55);
    chk_all("reset", 1, 8'h00, 0, 1, 0);
    reset = 0;

    // Reset BRK sequence runs from T1.
    step(1, ADV, 8'h11);  chk_all("rst_t2", 2, 8'h00, 0, 1, 0);
    step(1, ADV, 8'h11);  chk_all("rst_t3", 3, 8'h00, 0, 1, 0);
    step(1, ENDI, 8'h11); chk_all("rst_end", 0, 8'h00, 1, 1, 0);

    // Two-cycle LDA #.
    step(1, ADV, 8'hA9);  chk_all("lda_t1", 1, 8'hA9, 0, 0, 0);
    step(1, ENDI, 8'h00); chk_all("lda_end", 0, 8'hA9, 1, 0, 0);

    // Branch not taken / taken, page fix taken and not.
    step(1, ADV, 8'h90);         chk("bcc_t1", State, 1);
    step(1, BR, 8'h00, 0, 1);    chk("bcc_nt", State, 0);
    step(1, ADV, 8'hF0);         chk("beq_t1", State, 1);
    step(1, BR, 8'h00, 1, 0);    chk("beq_tk", State, 2);
    step(1, PF, 8'h00, 0, 1);    chk("pf_tk", State, 3);
    step(1, PF, 8'h00, 1, 0);    chk("pf_nt", State, 0);

    // Saturation: ADV out of T6 ends the instruction.
    step(1, ENDI, 8'hEA);
    for (int unsigned i = 0; i < 5; i++) step(1, ADV, 8'h00);
    chk("sat_t6", State, 6);
    step(1, ADV, 8'h00);
    chk("sat_wrap", State, 0);
    chk("sat_sync", sync, 1);

    // Masked IRQ is ignored.
    irq_n = 0; iflag = 1;
    step(1, ADV, 8'h4C); chk("irq_masked_ir", IR, 8'h4C);
    chk("irq_masked_int", in_int, 0);

    // NMI edge mid-instruction with an unmasked IRQ also waiting.
    irq_n = 1;
    nmi_n = 0; step(1, ADV, 8'h00);
    nmi_n = 1; step(1, ADV, 8'h00);
    irq_n = 0; iflag = 0;
    step(1, ENDI, 8'h00); chk("nmi_pre_t0", State, 0);
    step(1, ADV, 8'hAD);  chk_all("nmi_take", 1, 8'h00, 0, 1, 1);
    step(1, ENDI, 8'h00);
    step(1, ADV, 8'hAD);  chk_all("irq_take", 1, 8'h00, 0, 1, 0);
    irq_n = 1; iflag = 1;
    step(1, ENDI, 8'h00);

    // ce gating: ce=0 holds State and nmi_prev; edge seen at next ce.
    step(1, ADV, 8'hAD); step(1, ADV, 8'h00);
    chk("ce_start", State, 2);
    step(1, ADV, 8'h00); chk("ce_adv", State, 3);
    nmi_n = 0;
    step(0, ENDI, 8'h00); chk("ce_hold1", State, 3);
    step(0, ENDI, 8'h00); chk("ce_hold2", State, 3);
    step(1, ADV, 8'h00);  chk("ce_resume", State, 4);
    nmi_n = 1;
    step(1, ENDI, 8'h00);
    step(1, ADV, 8'h6D);  chk("ce_nmi_taken", is_nmi, 1);
    chk("ce_nmi_ir", IR, 8'h00);
    step(1, ENDI, 8'h00);

    // Reset at T5 with ce low, with an NMI edge pending.
    step(1, ADV, 8'h6D);
    nmi_n = 0; step(1, ADV, 8'h00);
    nmi_n = 1; step(1, ADV, 8'h00);
    step(1, ADV, 8'h00); step(1, ADV, 8'h00);
    chk("pre_reset_t5", State, 5);
    reset = 1; step(0, ADV, 8'h00);
    chk_all("mid_reset", 1, 8'h00, 0, 1, 0);
    reset = 0;
    step(1, ENDI, 8'h00);
    step(1, ADV, 8'hE8); chk("pend_cleared_ir", IR, 8'hE8);
    chk("pend_cleared_int", in_int, 0);
    step(1, ENDI, 8'h00);

    // A few cycles of random NEXT with interrupts quiet; model covers these.
    for (int i = 0; i < 40; i++)
      step(1, 2'($urandom_range(0, 3)), 8'($urandom()), 1'($urandom()), 1'($urandom()));

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
